program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream boot stage for the SUBLEQ core.
- Accepts a byte stream over a valid/ready handshake, assembles the bytes into WORD_SIZE instruction words and writes them into program memory through one write port.
- Holds the core in reset until the image is fully written, then releases it.
- Sits between the byte source (UART receiver / testbench) and the dual-port program memory plus core reset.

Parameters:
WORD_SIZE, gc::WORD_SIZE, width of memory words and addresses
LOAD_BASE, 0, memory address of the first loaded word
MAX_WORDS, 256, largest accepted image length in words; longer requests are an error

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous and active-low; one clock domain (clk) only
in_data  input  8  stream byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready at posedge
reload  input  1  single-cycle pulse: restart loading from DONE or ERR; ignored in other states
mem_addr  output  WORD_SIZE  write address
mem_data  output  WORD_SIZE  write data
mem_write  output  1  write strobe, exactly one cycle per word
core_rst  output  1  active-high reset to the core; 1 while loading
done  output  1  image loaded, core running
err  output  1  image length rejected
words_loaded  output  16  number of words written so far

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CNT_LO, core_rst=1, in_ready=0, mem_write=0, mem_addr=0, mem_data=0, done=0, err=0, words_loaded=0.
  - Byte index and word count are cleared; any partial word is discarded.
  - in_ready rises on the first posedge after rst deasserts.
- Stream format:
  - 16-bit word count N, sent low byte first.
  - Then N words of BPW = ceil(WORD_SIZE/8) bytes each, little-endian.
  - If WORD_SIZE is not a multiple of 8, the excess upper bits of the final byte are dropped.
- States:
  - CNT_LO: accept byte -> N[7:0]; go to CNT_HI.
  - CNT_HI: accept byte -> N[15:8]. Then:
    - N==0 -> DONE.
    - N>MAX_WORDS -> ERR.
    - otherwise -> DATA with byte index 0.
  - DATA: each accepted byte goes into lane [8*i +: 8] of the assembly register. When the accepted byte is lane BPW-1, go to WRITE.
  - WRITE (one cycle): in_ready=0, mem_write=1, mem_addr=LOAD_BASE+words_loaded, mem_data=assembled word. words_loaded increments at the end of the cycle. If the new words_loaded==N -> DONE, else -> DATA.
  - DONE: core_rst=0, done=1, in_ready=0. reload -> CNT_LO with core_rst=1, done=0, words_loaded=0.
  - ERR: err=1, core_rst=1, in_ready=0. reload -> CNT_LO with err=0.
- Timing:
  - in_ready=1 only in CNT_LO, CNT_HI and DATA.
  - If the last byte of a word is accepted at edge t, mem_write is high during cycle t..t+1, and the next byte can be accepted at edge t+2.
  - core_rst falls one cycle after the final mem_write cycle. The write completes before the core leaves reset; memory samples on the falling edge, and the strobe is held for a full cycle.
- Address arithmetic is modulo 2^WORD_SIZE; wrap-around is not checked.
- Bytes presented while in_ready=0 are not consumed. The source must hold them stable until accepted.
- Reset during DATA or WRITE: a partially written image is left in memory, and core_rst stays 1 until a complete load finishes.
- reload arriving in the same cycle as the transition into DONE/ERR is ignored.

Decomposition:
- Package gc (urisc.svh) additions:
  - loader_state_e enum (CNT_LO, CNT_HI, DATA, WRITE, DONE, ERR).
  - constants BYTES_PER_WORD and LOADER_MAX_WORDS.
- No sub-module needed. A small byte_assembler (shift/lane register with a byte counter) is a natural split if it is reused by a future UART debug port.

Test Plan:
- Reset-value check: assert rst=0 mid-stream, release -> all outputs at their reset values; in_ready=1 one cycle after release.
- WORD_SIZE=32, LOAD_BASE=0, stream 02 00 | 0C 00 00 00 | 0D 00 00 00 ->
  - mem_write pulses at addr 0 data 0x0000000C and at addr 1 data 0x0000000D.
  - core_rst falls one cycle after the 2nd pulse; done=1; words_loaded=2.
- Backpressure: keep in_valid=1 continuously -> in_ready drops for exactly 1 cycle after each 4th data byte; no byte is lost or duplicated (compare the memory model against the source image).
- Count 0x0000 -> DONE immediately with no mem_write. Count MAX_WORDS+1 (0x0101) -> err=1, core_rst stays 1, in_ready=0.
- From DONE, pulse reload, then send a 1-word image 01 00 | FF FF FF FF -> core_rst rises again, then falls after addr 0 is written with 0xFFFFFFFF.
- rst pulsed low between bytes 2 and 3 of word 1 -> word 1 is not written; a fresh complete stream then loads correctly from LOAD_BASE.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the SUBLEQ boot loader: word geometry,
// the image length limit and the loader state encoding.
package program_loader_pkg;

  localparam int WORD_SIZE        = 32;
  localparam int LOADER_MAX_WORDS = 256;

  function automatic int bytes_per_word(input int ws);
    return (ws + 7) / 8;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(WORD_SIZE);

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } loader_state_e;

endpackage

// File: rtl/program_loader_byte_asm.sv
// Little-endian byte-to-word assembler: each loaded byte fills the next lane,
// o_last flags that the current lane is the final one of the word.
module program_loader_byte_asm #(
  parameter int WORD_SIZE = 32,
  parameter int BPW       = (WORD_SIZE + 7) / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [7:0]           i_byte,
  output logic [WORD_SIZE-1:0] o_word,
  output logic                 o_last
);

  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [8*BPW-1:0] r_lanes;
  logic [IDX_W-1:0] r_idx;

  assign o_last = (r_idx == IDX_W'(BPW - 1));
  // Upper bits of the final lane beyond WORD_SIZE are dropped here.
  assign o_word = r_lanes[WORD_SIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lanes <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_load) begin
      for (int l = 0; l < BPW; l++) begin
        if (r_idx == IDX_W'(l)) r_lanes[8*l +: 8] <= i_byte;
      end
      r_idx <= o_last ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it word by word
// into program memory and holds the SUBLEQ core in reset until it is complete.
module program_loader #(
  parameter int WORD_SIZE = program_loader_pkg::WORD_SIZE,
  parameter int LOAD_BASE = 0,
  parameter int MAX_WORDS = program_loader_pkg::LOADER_MAX_WORDS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              reload,
  output logic [WORD_SIZE-1:0]              mem_addr,
  output logic [WORD_SIZE-1:0]              mem_data,
  output logic                              mem_write,
  output logic                              core_rst,
  output logic                              done,
  output logic                              err,
  output logic [15:0]                       words_loaded,
  output program_loader_pkg::loader_state_e dbg_state
);

  import program_loader_pkg::*;

  localparam int          BPW      = bytes_per_word(WORD_SIZE);
  localparam logic [16:0] MAX_W17  = 17'(MAX_WORDS);

  // Handshake: a byte transfers at a rising edge where in_valid && in_ready;
  // the source holds in_data stable until then.
  loader_state_e          r_state;
  loader_state_e          w_next;
  logic                   r_armed;
  logic [15:0]            r_count;
  logic [15:0]            r_words;
  logic                   w_fire;
  logic [15:0]            w_cnt_full;
  logic [WORD_SIZE-1:0]   w_word;
  logic                   w_last;

  assign w_fire     = in_valid && in_ready;
  assign w_cnt_full = {in_data, r_count[7:0]};

  program_loader_byte_asm #(
    .WORD_SIZE (WORD_SIZE),
    .BPW       (BPW)
  ) u_asm (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (r_state == CNT_HI),
    .i_load  (w_fire && (r_state == DATA)),
    .i_byte  (in_data),
    .o_word  (w_word),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CNT_LO;
      r_armed <= 1'b0;
      r_count <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_next;
      // in_ready stays low for the first cycle after reset release.
      r_armed <= 1'b1;
      if (r_state == CNT_LO && w_fire) r_count[7:0]  <= in_data;
      if (r_state == CNT_HI && w_fire) r_count[15:8] <= in_data;
      if (r_state == WRITE) r_words <= r_words + 16'd1;
      else if (r_state == DONE && reload) r_words <= '0;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    core_rst  = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      CNT_LO: begin
        in_ready = r_armed;
        if (w_fire) w_next = CNT_HI;
      end
      CNT_HI: begin
        in_ready = r_armed;
        if (w_fire) begin
          if (w_cnt_full == 16'd0)                w_next = DONE;
          else if ({1'b0, w_cnt_full} > MAX_W17) w_next = ERR;
          else                                    w_next = DATA;
        end
      end
      DATA: begin
        in_ready = r_armed;
        if (w_fire && w_last) w_next = WRITE;
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = WORD_SIZE'(LOAD_BASE) + WORD_SIZE'(r_words);
        mem_data  = w_word;
        w_next    = (r_words + 16'd1 == r_count) ? DONE : DATA;
      end
      DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (reload) w_next = CNT_LO;
      end
      ERR: begin
        err = 1'b1;
        if (reload) w_next = CNT_LO;
      end
      default: w_next = CNT_LO;
    endcase
  end

  assign words_loaded = r_words;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with WORD_SIZE=32, LOAD_BASE=0, MAX_WORDS=256.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int W    = 32;
  localparam int SB_W = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          reload = 1'b0;
  logic [W-1:0]  mem_addr, mem_data;
  logic          mem_write, core_rst, done, err;
  logic [15:0]   words_loaded;
  loader_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SB_W-1:0] exp_q[$];

  program_loader #(.WORD_SIZE(W), .LOAD_BASE(0), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_write(mem_write), .core_rst(core_rst),
    .done(done), .err(err), .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // driver: present a byte and return at the negedge after it was taken
  task automatic send_byte(input logic [7:0] b, output int waited);
    in_data = b; in_valid = 1'b1; waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("handshake", in_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // scoreboard: every write strobe must match the next expected {addr,data}
  always @(negedge clk) begin
    if (mem_write) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: addr=%0h data=%0h, no write expected", mem_addr, mem_data);
      end else begin
        logic [SB_W-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          n_fail++;
          $display("FAIL wr_match: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   mem_addr, mem_data, e[SB_W-1:W], e[W-1:0]);
        end
      end
    end
  end

  typedef struct {
    logic [15:0] cnt;
    logic        done;
    logic        err;
    logic        crst;
    logic        rdy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w;
    vecs[0] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0101, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h0100, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{16'h0001, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0102, 1'b0, 1'b1, 1'b1, 1'b0};

    // Power-on reset, then a reset asserted mid-stream
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_byte(8'h02, w); send_byte(8'h00, w); send_byte(8'h0C, w);
    idle();
    rst = 1'b0;
    #1;
    chk("rst_state", dbg_state, CNT_LO);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_write", mem_write, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_data", mem_data, '0);
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_words", words_loaded, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_at_release", in_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_release", in_ready, 1'b1);

    // Two-word image with in_valid held high throughout
    exp_q.push_back({32'd0, 32'h0000000C});
    exp_q.push_back({32'd1, 32'h0000000D});
    send_byte(8'h02, w); send_byte(8'h00, w);
    send_byte(8'h0C, w); send_byte(8'h00, w); send_byte(8'h00, w); send_byte(8'h00, w);
    chk("bp_write_pulse", mem_write, 1'b1);
    chk("bp_ready_low", in_ready, 1'b0);
    send_byte(8'h0D, w);
    chk("bp_wait_cycles", w, 1);
    send_byte(8'h00, w); send_byte(8'h00, w); send_byte(8'h00, w);
    idle();
    chk("w2_core_rst_during_write", core_rst, 1'b1);
    chk("w2_done_during_write", done, 1'b0);
    @(negedge clk);
    chk("w2_core_rst", core_rst, 1'b0);
    chk("w2_done", done, 1'b1);
    chk("w2_words", words_loaded, 16'd2);
    chk("w2_ready", in_ready, 1'b0);

    // Reload from DONE and load a single all-ones word
    pulse_reload();
    chk("reload_core_rst", core_rst, 1'b1);
    chk("reload_done", done, 1'b0);
    chk("reload_words", words_loaded, 16'd0);
    chk("reload_ready", in_ready, 1'b1);
    exp_q.push_back({32'd0, 32'hFFFFFFFF});
    send_byte(8'h01, w); send_byte(8'h00, w);
    for (int i = 0; i < 4; i++) send_byte(8'hFF, w);
    idle();
    chk("ones_core_rst_write", core_rst, 1'b1);
    @(negedge clk);
    chk("ones_core_rst", core_rst, 1'b0);
    chk("ones_words", words_loaded, 16'd1);

    // Count-header vectors
    for (int i = 0; i < 6; i++) begin
      do_reset();
      send_byte(vecs[i].cnt[7:0], w);
      send_byte(vecs[i].cnt[15:8], w);
      idle();
      chk($sformatf("cnt%0h_done", vecs[i].cnt), done, vecs[i].done);
      chk($sformatf("cnt%0h_err", vecs[i].cnt), err, vecs[i].err);
      chk($sformatf("cnt%0h_core_rst", vecs[i].cnt), core_rst, vecs[i].crst);
      chk($sformatf("cnt%0h_ready", vecs[i].cnt), in_ready, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("cnt%0h_hold_err", vecs[i].cnt), err, vecs[i].err);
    end
    pulse_reload();
    chk("err_reload_err", err, 1'b0);
    chk("err_reload_ready", in_ready, 1'b1);

    // Reset between bytes 2 and 3 of the second word
    do_reset();
    exp_q.push_back({32'd0, 32'h00000011});
    send_byte(8'h02, w); send_byte(8'h00, w);
    send_byte(8'h11, w); send_byte(8'h00, w); send_byte(8'h00, w); send_byte(8'h00, w);
    send_byte(8'hAA, w); send_byte(8'hBB, w);
    idle();
    do_reset();
    chk("partial_core_rst", core_rst, 1'b1);
    chk("partial_words", words_loaded, 16'd0);
    exp_q.push_back({32'd0, 32'h11223344});
    send_byte(8'h01, w); send_byte(8'h00, w);
    send_byte(8'h44, w); send_byte(8'h33, w); send_byte(8'h22, w); send_byte(8'h11, w);
    idle();
    @(negedge clk);
    chk("fresh_done", done, 1'b1);
    chk("fresh_words", words_loaded, 16'd1);

    repeat (3) @(negedge clk);
    chk("writes_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
